topbus_master: RTL and testbench

TOPBUS_MASTER -- requirements
Module: topbus_master

---
 rtl/topbus_master_if.sv | 34 +++
 rtl/topbus_master.sv | 159 +++++++++++++++
 tb/tb_topbus_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/topbus_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// topbus_master_if : host command/response and multiplexed bus signal bundle
// Revision 1.0
// ============================================================================
interface topbus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [7:0] bus_data_out;
    logic       bus_data_oe;
    logic [7:0] bus_data_in;
    logic       ale;
    logic       write;
    logic       read;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_data_in,
        output cmd_ready, rsp_valid, rsp_rdata, bus_data_out, bus_data_oe,
        output ale, write, read
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, bus_data_in,
        input  cmd_ready, rsp_valid, rsp_rdata, bus_data_out, bus_data_oe,
        input  ale, write, read
    );
endinterface
`default_nettype wire

// File: rtl/topbus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// topbus_master : single-transaction ALE/strobe master for a muxed 8-bit bus
// Revision 1.0
// ============================================================================
module topbus_master #(
    parameter int T_ALE    = 2,
    parameter int T_HOLD   = 1,
    parameter int T_STROBE = 3
) (
    input wire              osc,
    input wire              rst_n,
    topbus_master_if.master bus
);

    localparam logic [7:0] c_ale_load    = 8'(T_ALE - 1);
    localparam logic [7:0] c_hold_load   = 8'(T_HOLD - 1);
    localparam logic [7:0] c_strobe_load = 8'(T_STROBE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ALE     = 3'd1,
        ST_AHOLD   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    state_t     r_state,     w_state;
    logic [7:0] r_cnt,       w_cnt;
    logic       r_is_write,  w_is_write;
    logic [7:0] r_wdata,     w_wdata;
    logic       r_ale,       w_ale;
    logic       r_write_n,   w_write_n;
    logic       r_read_n,    w_read_n;
    logic       r_oe,        w_oe;
    logic [7:0] r_dout,      w_dout;
    logic       r_rsp_valid, w_rsp_valid;
    logic [7:0] r_rdata,     w_rdata;
    logic       w_cnt_zero;

    assign w_cnt_zero = (r_cnt == 8'd0);

    always_ff @(posedge osc or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_is_write  <= 1'b0;
            r_wdata     <= 8'h00;
            r_ale       <= 1'b0;
            r_write_n   <= 1'b1;
            r_read_n    <= 1'b1;
            r_oe        <= 1'b0;
            r_dout      <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 8'h00;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_is_write  <= w_is_write;
            r_wdata     <= w_wdata;
            r_ale       <= w_ale;
            r_write_n   <= w_write_n;
            r_read_n    <= w_read_n;
            r_oe        <= w_oe;
            r_dout      <= w_dout;
            r_rsp_valid <= w_rsp_valid;
            r_rdata     <= w_rdata;
        end
    end

    // Every bus-visible output is computed here one cycle early and registered.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_is_write  = r_is_write;
        w_wdata     = r_wdata;
        w_ale       = r_ale;
        w_write_n   = r_write_n;
        w_read_n    = r_read_n;
        w_oe        = r_oe;
        w_dout      = r_dout;
        w_rsp_valid = 1'b0;
        w_rdata     = r_rdata;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_is_write = bus.cmd_write;
                    w_wdata    = bus.cmd_wdata;
                    w_dout     = bus.cmd_addr;
                    w_oe       = 1'b1;
                    w_ale      = 1'b1;
                    w_cnt      = c_ale_load;
                    w_state    = ST_ALE;
                end
            end
            ST_ALE: begin
                if (w_cnt_zero) begin
                    w_ale   = 1'b0;
                    w_cnt   = c_hold_load;
                    w_state = ST_AHOLD;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            ST_AHOLD: begin
                if (w_cnt_zero) begin
                    if (r_is_write) begin
                        w_dout    = r_wdata;
                        w_write_n = 1'b0;
                    end else begin
                        w_oe     = 1'b0;
                        w_read_n = 1'b0;
                    end
                    w_cnt   = c_strobe_load;
                    w_state = ST_STROBE;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            ST_STROBE: begin
                if (w_cnt_zero) begin
                    w_write_n   = 1'b1;
                    w_read_n    = 1'b1;
                    if (!r_is_write) begin
                        w_rdata = bus.bus_data_in;
                    end
                    w_rsp_valid = 1'b1;
                    w_cnt       = c_hold_load;
                    w_state     = ST_RECOVER;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            ST_RECOVER: begin
                if (w_cnt_zero) begin
                    w_oe    = 1'b0;
                    w_state = ST_IDLE;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready    = (r_state == ST_IDLE);
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata    = r_rdata;
    assign bus.bus_data_out = r_dout;
    assign bus.bus_data_oe  = r_oe;
    assign bus.ale          = r_ale;
    assign bus.write        = r_write_n;
    assign bus.read         = r_read_n;

endmodule
`default_nettype wire

// File: tb/tb_topbus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_topbus_master : two parameterisations checked against a cycle-offset model
// Revision 1.0
// ============================================================================
module tb_topbus_master;

    localparam int A0 = 2, H0 = 1, S0 = 3;
    localparam int A1 = 1, H1 = 1, S1 = 1;

    logic osc = 1'b0;
    logic rst_n0, rst_n1;
    always #5 osc = ~osc;

    topbus_master_if ifc0();
    topbus_master_if ifc1();

    topbus_master #(.T_ALE(A0), .T_HOLD(H0), .T_STROBE(S0)) dut0 (
        .osc(osc), .rst_n(rst_n0), .bus(ifc0.master));
    topbus_master #(.T_ALE(A1), .T_HOLD(H1), .T_STROBE(S1)) dut1 (
        .osc(osc), .rst_n(rst_n1), .bus(ifc1.master));

    int errors = 0;
    int checks = 0;

    // Model: cycles elapsed since the accept edge (0 = idle) plus the latched command.
    int         pa[2], ph[2], ps[2];
    int         m_ofs[2];
    logic       m_wr[2];
    logic [7:0] m_addr[2], m_wd[2], m_rd[2];
    int         cnt_ale[2], cnt_wstr[2], cnt_rstr[2], cnt_rsp[2];
    logic [7:0] lit_addr[2], lit_data[2];

    // Vector layout: {ready, ale, write_n, read_n, oe, rsp_valid, rdata[7:0], dout[7:0]}
    function automatic logic [21:0] act_vec(input int i);
        if (i == 0)
            return {ifc0.cmd_ready, ifc0.ale, ifc0.write, ifc0.read, ifc0.bus_data_oe,
                    ifc0.rsp_valid, ifc0.rsp_rdata, ifc0.bus_data_out};
        return {ifc1.cmd_ready, ifc1.ale, ifc1.write, ifc1.read, ifc1.bus_data_oe,
                ifc1.rsp_valid, ifc1.rsp_rdata, ifc1.bus_data_out};
    endfunction

    function automatic logic rstn_of(input int i);
        return (i == 0) ? rst_n0 : rst_n1;
    endfunction

    function automatic logic [21:0] exp_vec(input int i);
        int d, a, h, s;
        logic strobe, oe;
        logic [7:0] dout;
        if (!rstn_of(i)) return {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
        d = m_ofs[i]; a = pa[i]; h = ph[i]; s = ps[i];
        strobe = (d > a + h) && (d <= a + h + s);
        oe     = (d >= 1 && d <= a + h) || (d > a + h && m_wr[i]);
        dout   = (d <= a + h) ? m_addr[i] : m_wd[i];
        return {d == 0, d >= 1 && d <= a, !(strobe && m_wr[i]), !(strobe && !m_wr[i]),
                oe, d == a + h + s + 1, m_rd[i], dout};
    endfunction

    task automatic check(input string name, input int i, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h, required %0h", name, i, got, want);
        end
    endtask

    task automatic model_edge(input int i, input logic rstn, input logic v, input logic w,
                              input logic [7:0] a, input logic [7:0] d, input logic [7:0] b);
        if (!rstn) begin
            m_ofs[i] = 0;
            m_rd[i]  = 8'h00;
        end else if (m_ofs[i] == 0) begin
            if (v) begin
                m_ofs[i] = 1; m_wr[i] = w; m_addr[i] = a; m_wd[i] = d;
            end
        end else begin
            if (m_ofs[i] == pa[i] + ph[i] + ps[i] && !m_wr[i]) m_rd[i] = b;
            if (m_ofs[i] == pa[i] + 2 * ph[i] + ps[i]) m_ofs[i] = 0;
            else m_ofs[i] = m_ofs[i] + 1;
        end
    endtask

    task automatic compare_all();
        logic [21:0] e, a, raw;
        logic inv;
        for (int i = 0; i < 2; i++) begin
            e = exp_vec(i);
            raw = act_vec(i);
            a = raw;
            if (rstn_of(i) && !e[17]) begin
                a[7:0] = 8'h00;
                e[7:0] = 8'h00;
            end
            check("cycle", i, 32'(a), 32'(e));
            inv = !(!raw[19] && !raw[18]) && !(raw[20] && (!raw[19] || !raw[18]))
                  && !(!raw[18] && raw[17]);
            check("invariant", i, 32'(inv), 32'd1);
            if (raw[20] && raw[7:0] == lit_addr[i]) cnt_ale[i]++;
            if (!raw[19] && raw[7:0] == lit_data[i]) cnt_wstr[i]++;
            if (!raw[18] && !raw[17]) cnt_rstr[i]++;
            if (raw[16]) cnt_rsp[i]++;
        end
    endtask

    task automatic step();
        @(posedge osc);
        model_edge(0, rst_n0, ifc0.cmd_valid, ifc0.cmd_write, ifc0.cmd_addr,
                   ifc0.cmd_wdata, ifc0.bus_data_in);
        model_edge(1, rst_n1, ifc1.cmd_valid, ifc1.cmd_write, ifc1.cmd_addr,
                   ifc1.cmd_wdata, ifc1.bus_data_in);
        @(negedge osc);
        compare_all();
    endtask

    task automatic drive(input int i, input logic v, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        if (i == 0) begin
            ifc0.cmd_valid = v; ifc0.cmd_write = w; ifc0.cmd_addr = a; ifc0.cmd_wdata = d;
        end else begin
            ifc1.cmd_valid = v; ifc1.cmd_write = w; ifc1.cmd_addr = a; ifc1.cmd_wdata = d;
        end
    endtask

    task automatic set_busin(input int i, input logic [7:0] b);
        if (i == 0) ifc0.bus_data_in = b;
        else        ifc1.bus_data_in = b;
    endtask

    task automatic set_rst(input int i, input logic r);
        if (i == 0) rst_n0 = r;
        else        rst_n1 = r;
    endtask

    task automatic clear_counts(input int i, input logic [7:0] la, input logic [7:0] ld);
        cnt_ale[i] = 0; cnt_wstr[i] = 0; cnt_rstr[i] = 0; cnt_rsp[i] = 0;
        lit_addr[i] = la; lit_data[i] = ld;
    endtask

    task automatic measure(input int i, output int n);
        logic [21:0] v;
        n = 0;
        v = act_vec(i);
        while (!v[21] && n < 64) begin
            step();
            n++;
            v = act_vec(i);
        end
        if (!v[21]) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout inst%0d: cmd_ready still 0 after %0d cycles, required 1", i, n);
        end
    endtask

    task automatic directed(input int i);
        int n, lat_lit, a_lit, s_lit;
        logic [21:0] v;
        lat_lit = (i == 0) ? 7 : 4;
        a_lit   = (i == 0) ? 2 : 1;
        s_lit   = (i == 0) ? 3 : 1;

        clear_counts(i, 8'h13, 8'h5A);
        drive(i, 1'b1, 1'b1, 8'h13, 8'h5A);
        step();
        drive(i, 1'b0, 1'b0, 8'h00, 8'h00);
        measure(i, n);
        check("wr_latency", i, 32'(n), 32'(lat_lit));
        check("wr_ale_cycles", i, 32'(cnt_ale[i]), 32'(a_lit));
        check("wr_strobe_cycles", i, 32'(cnt_wstr[i]), 32'(s_lit));
        check("wr_rsp_pulses", i, 32'(cnt_rsp[i]), 32'd1);

        clear_counts(i, 8'h10, 8'h00);
        set_busin(i, 8'hA5);
        drive(i, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        drive(i, 1'b0, 1'b0, 8'h00, 8'h00);
        measure(i, n);
        v = act_vec(i);
        check("rd_rdata", i, 32'(v[15:8]), 32'h0000_00A5);
        check("rd_strobe_cycles", i, 32'(cnt_rstr[i]), 32'(s_lit));
        check("rd_rsp_pulses", i, 32'(cnt_rsp[i]), 32'd1);

        clear_counts(i, 8'h14, 8'h1F);
        set_busin(i, 8'h01);
        drive(i, 1'b1, 1'b1, 8'h14, 8'h1F);
        step();
        drive(i, 1'b1, 1'b0, 8'h12, 8'h00);
        measure(i, n);
        check("b2b_gap", i, 32'(n), 32'(lat_lit));
        step();
        v = act_vec(i);
        check("b2b_second_accept", i, 32'(v[21]), 32'd0);
        drive(i, 1'b0, 1'b0, 8'h00, 8'h00);
        measure(i, n);
        v = act_vec(i);
        check("b2b_rdata", i, 32'(v[15:8]), 32'h0000_0001);
        check("b2b_rsp_pulses", i, 32'(cnt_rsp[i]), 32'd2);

        // Address keeps moving while valid stays high: only the accept-edge value may appear.
        clear_counts(i, 8'h20, 8'h00);
        drive(i, 1'b1, 1'b0, 8'h20, 8'h00);
        step();
        for (int k = 1; k < lat_lit; k++) begin
            drive(i, 1'b1, 1'($urandom), 8'(8'h40 + k), 8'($urandom));
            step();
        end
        drive(i, 1'b0, 1'b0, 8'h00, 8'h00);
        measure(i, n);
        check("hold_ale_cycles", i, 32'(cnt_ale[i]), 32'(a_lit));
        check("hold_rsp_pulses", i, 32'(cnt_rsp[i]), 32'd1);

        drive(i, 1'b1, 1'b1, 8'h33, 8'hC3);
        step();
        drive(i, 1'b0, 1'b0, 8'h00, 8'h00);
        n = 0;
        while (m_ofs[i] != pa[i] + ph[i] + 1 && n < 64) begin
            step();
            n++;
        end
        v = act_vec(i);
        check("pre_reset_in_strobe", i, 32'(v[19]), 32'd0);
        #2;
        set_rst(i, 1'b0);
        m_ofs[i] = 0;
        m_rd[i]  = 8'h00;
        #1;
        v = act_vec(i);
        check("reset_abort", i, 32'({v[20], v[19], v[18], v[17], v[16]}), 32'b01100);
        step();
        step();
        set_rst(i, 1'b1);
        clear_counts(i, 8'h44, 8'h99);
        drive(i, 1'b1, 1'b1, 8'h44, 8'h99);
        step();
        drive(i, 1'b0, 1'b0, 8'h00, 8'h00);
        measure(i, n);
        check("post_reset_latency", i, 32'(n), 32'(lat_lit));
        check("post_reset_rsp_pulses", i, 32'(cnt_rsp[i]), 32'd1);
    endtask

    initial begin
        pa[0] = A0; ph[0] = H0; ps[0] = S0;
        pa[1] = A1; ph[1] = H1; ps[1] = S1;
        for (int i = 0; i < 2; i++) begin
            m_ofs[i] = 0; m_wr[i] = 1'b0; m_addr[i] = 8'h00; m_wd[i] = 8'h00; m_rd[i] = 8'h00;
            clear_counts(i, 8'h00, 8'h00);
            drive(i, 1'b0, 1'b0, 8'h00, 8'h00);
            set_busin(i, 8'h00);
            set_rst(i, 1'b0);
        end
        step();
        step();
        set_rst(0, 1'b1);
        set_rst(1, 1'b1);

        directed(0);
        directed(1);

        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                drive(i, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
                set_busin(i, 8'($urandom));
            end
            step();
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int c = 0; c < 10; c++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
